spi_mem_arbiter: RTL and testbench

//  Shares the single SPI memory controller between the CPU fetch port (flash reads, 16-bit) and data port
//  (PSRAM 8-bit read/write). Arbitrates, launches one controller transaction at a time, captures the result,

---
 rtl/spi_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Arbiter sharing one SPI memory controller between the fetch and data ports.
// One transaction in flight at a time, with a watchdog that aborts hung transfers.
module spi_mem_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        fetch_req_in,
  input  logic [15:0] fetch_addr_in,
  output logic [15:0] fetch_data_out,
  output logic        fetch_ack_out,
  input  logic        data_req_in,
  input  logic        data_we_in,
  input  logic [15:0] data_addr_in,
  input  logic [7:0]  data_wdata_in,
  output logic [7:0]  data_rdata_out,
  output logic        data_ack_out,
  output logic        err_out,
  output logic [15:0] mem_addr_out,
  output logic        mem_addr_valid_out,
  output logic [1:0]  mem_type_out,
  output logic [7:0]  mem_wdata_out,
  input  logic [15:0] mem_flash_data_in,
  input  logic        mem_flash_data_valid_in,
  input  logic [7:0]  mem_psram_data_in,
  input  logic        mem_psram_data_valid_in,
  input  logic        mem_busy_in
);

  typedef enum logic [1:0] {
    IDLE, ISSUE_WAIT, XFER, ACK
  } state_t;

  localparam logic [1:0] T_FLASH = 2'b01;
  localparam logic [1:0] T_PRD   = 2'b10;
  localparam logic [1:0] T_PWR   = 2'b11;
  localparam logic [7:0] TMO     = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [7:0] cnt;
  logic       last_data;
  logic       own_data;
  logic       pick_data;
  logic       done;
  logic       fin;
  logic       tmo;

  always_comb begin
    pick_data = data_req_in;
    if (data_req_in && fetch_req_in)
      pick_data = (ROUND_ROBIN != 0) ? !last_data : 1'b1;
  end

  // Completion event depends on the kind of transaction in flight
  always_comb begin
    done = 1'b0;
    unique case (mem_type_out)
      T_FLASH: done = mem_flash_data_valid_in;
      T_PRD:   done = mem_psram_data_valid_in;
      T_PWR:   done = !mem_busy_in;
      default: done = 1'b0;
    endcase
  end

  assign fin = (state == XFER) && done;
  assign tmo = !fin && (cnt == TMO);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state              <= IDLE;
      cnt                <= 8'h00;
      last_data          <= 1'b0;
      own_data           <= 1'b0;
      fetch_data_out     <= 16'h0000;
      fetch_ack_out      <= 1'b0;
      data_rdata_out     <= 8'h00;
      data_ack_out       <= 1'b0;
      err_out            <= 1'b0;
      mem_addr_out       <= 16'h0000;
      mem_addr_valid_out <= 1'b0;
      mem_type_out       <= 2'b00;
      mem_wdata_out      <= 8'h00;
    end else begin
      mem_addr_valid_out <= 1'b0;
      fetch_ack_out      <= 1'b0;
      data_ack_out       <= 1'b0;
      err_out            <= 1'b0;
      case (state)
        IDLE: begin
          if ((fetch_req_in || data_req_in) && !mem_busy_in) begin
            own_data           <= pick_data;
            last_data          <= pick_data;
            cnt                <= 8'h00;
            mem_addr_valid_out <= 1'b1;
            state              <= ISSUE_WAIT;
            if (pick_data) begin
              mem_addr_out  <= data_addr_in;
              mem_type_out  <= data_we_in ? T_PWR : T_PRD;
              mem_wdata_out <= data_wdata_in;
            end else begin
              mem_addr_out <= fetch_addr_in;
              mem_type_out <= T_FLASH;
            end
          end
        end
        ISSUE_WAIT, XFER: begin
          if (fin || tmo) begin
            state   <= ACK;
            err_out <= tmo;
            if (own_data) begin
              data_ack_out   <= 1'b1;
              data_rdata_out <= (tmo || mem_type_out != T_PRD)
                                ? 8'h00 : mem_psram_data_in;
            end else begin
              fetch_ack_out  <= 1'b1;
              fetch_data_out <= tmo ? 16'h0000 : mem_flash_data_in;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (state == ISSUE_WAIT && mem_busy_in)
              state <= XFER;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: round-robin and fixed-priority instances
// driven against a small SPI controller model.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic        req1_f = 1'b0, req1_d = 1'b0;
  logic [15:0] fetch_addr = '0, data_addr = '0;
  logic [7:0]  wdata = '0;
  logic [15:0] fdata = '0;
  logic [7:0]  pdata = '0;
  logic        hang = 1'b0, force_busy = 1'b0;

  logic [15:0] f_data0, f_data1, maddr0, maddr1;
  logic [7:0]  d_rdata0, d_rdata1, mwd0, mwd1;
  logic        f_ack0, f_ack1, d_ack0, d_ack1, err0, err1, av0, av1;
  logic [1:0]  mtype0, mtype1;
  logic        busy0, busy1;

  logic [1:0]      av;
  logic [1:0][1:0] ty;
  logic [1:0][2:0] mc = '0;
  logic [1:0]      fv = '0, pv = '0;

  assign av    = {av1, av0};
  assign ty    = {mtype1, mtype0};
  assign busy0 = (mc[0] != 3'd0) || force_busy;
  assign busy1 = (mc[1] != 3'd0) || force_busy;

  spi_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(20)) u0 (
    .clk_in(clk), .reset_in(rst),
    .fetch_req_in(fetch_req), .fetch_addr_in(fetch_addr),
    .fetch_data_out(f_data0), .fetch_ack_out(f_ack0),
    .data_req_in(data_req), .data_we_in(data_we),
    .data_addr_in(data_addr), .data_wdata_in(wdata),
    .data_rdata_out(d_rdata0), .data_ack_out(d_ack0), .err_out(err0),
    .mem_addr_out(maddr0), .mem_addr_valid_out(av0),
    .mem_type_out(mtype0), .mem_wdata_out(mwd0),
    .mem_flash_data_in(fdata), .mem_flash_data_valid_in(fv[0]),
    .mem_psram_data_in(pdata), .mem_psram_data_valid_in(pv[0]),
    .mem_busy_in(busy0)
  );

  spi_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(20)) u1 (
    .clk_in(clk), .reset_in(rst),
    .fetch_req_in(req1_f), .fetch_addr_in(fetch_addr),
    .fetch_data_out(f_data1), .fetch_ack_out(f_ack1),
    .data_req_in(req1_d), .data_we_in(data_we),
    .data_addr_in(data_addr), .data_wdata_in(wdata),
    .data_rdata_out(d_rdata1), .data_ack_out(d_ack1), .err_out(err1),
    .mem_addr_out(maddr1), .mem_addr_valid_out(av1),
    .mem_type_out(mtype1), .mem_wdata_out(mwd1),
    .mem_flash_data_in(fdata), .mem_flash_data_valid_in(fv[1]),
    .mem_psram_data_in(pdata), .mem_psram_data_valid_in(pv[1]),
    .mem_busy_in(busy1)
  );

  // Controller model: busy 3 cycles after the issue pulse, read data on the 2nd
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      fv[i] <= 1'b0;
      pv[i] <= 1'b0;
      if (av[i] && !hang) mc[i] <= 3'd1;
      else if (mc[i] == 3'd1) mc[i] <= 3'd2;
      else if (mc[i] == 3'd2) begin
        mc[i] <= 3'd3;
        fv[i] <= (ty[i] == 2'b01);
        pv[i] <= (ty[i] == 2'b10);
      end else if (mc[i] == 3'd3) mc[i] <= 3'd0;
    end
  end

  logic [1:0] q0[$], q1[$];
  int facks = 0, avn = 0;
  always @(posedge clk) begin
    if (av0) q0.push_back(mtype0);
    if (av1) q1.push_back(mtype1);
    if (f_ack0) facks <= facks + 1;
    if (av0) avn <= avn + 1;
  end

  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ack(input bit dport, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dport ? d_ack0 : f_ack0) && n < 60);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int a;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs0", {f_data0, d_rdata0, maddr0, mtype0, av0, f_ack0,
                      d_ack0, err0, mwd0}, 64'h0);
    chk("rst_outs1", {f_data1, d_rdata1, maddr1, mtype1, av1, f_ack1,
                      d_ack1, err1, mwd1}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fdata = 16'hA55A; fetch_addr = 16'h0010; fetch_req = 1'b1; a = avn;
    @(negedge clk);
    chk("f_issue", {av0, mtype0, maddr0}, {1'b1, 2'b01, 16'h0010});
    @(negedge clk);
    chk("f_av_pulse", av0, 0);
    wait_ack(0, n);
    chk("f_ack", {f_ack0, err0, f_data0, n[7:0]},
        {1'b1, 1'b0, 16'hA55A, 8'd3});
    fetch_req = 1'b0;
    @(negedge clk);
    chk("f_ack_1cyc", {f_ack0, avn - a}, {1'b0, 32'd1});

    pdata = 8'h3C; data_we = 1'b0; data_addr = 16'h0200; data_req = 1'b1;
    @(negedge clk);
    chk("r_issue", {av0, mtype0, maddr0}, {1'b1, 2'b10, 16'h0200});
    wait_ack(1, n);
    chk("r_ack", {d_ack0, err0, d_rdata0, n[7:0]},
        {1'b1, 1'b0, 8'h3C, 8'd4});
    data_req = 1'b0;
    @(negedge clk);

    data_we = 1'b1; data_addr = 16'h0123; wdata = 8'h5C; data_req = 1'b1;
    @(negedge clk);
    chk("w_issue", {av0, mtype0, maddr0, mwd0},
        {1'b1, 2'b11, 16'h0123, 8'h5C});
    wait_ack(1, n);
    chk("w_ack", {d_ack0, err0, d_rdata0, busy0, f_ack0, n[7:0]},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd5});
    data_req = 1'b0;
    @(negedge clk);

    q0.delete(); q1.delete();
    data_we = 1'b0; pdata = 8'h3C;
    fetch_req = 1'b1; data_req = 1'b1; req1_f = 1'b1; req1_d = 1'b1;
    n = 0;
    while ((q0.size() < 4 || q1.size() < 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    fetch_req = 1'b0; data_req = 1'b0; req1_f = 1'b0; req1_d = 1'b0;
    chk("rr_bound", n < 200, 1);
    chk("rr1_seq", {q0[0], q0[1], q0[2], q0[3]}, 8'b01_10_01_10);
    chk("rr0_seq", {q1[0], q1[1], q1[2], q1[3]}, 8'b10_10_10_10);
    repeat (10) @(negedge clk);

    hang = 1'b1; pdata = 8'h99; data_addr = 16'h0400; data_req = 1'b1;
    @(negedge clk);
    chk("t_issue", {av0, mtype0}, {1'b1, 2'b10});
    wait_ack(1, n);
    chk("t_ack", {d_ack0, err0, d_rdata0, n[7:0]},
        {1'b1, 1'b1, 8'h00, 8'd21});
    data_req = 1'b0;
    @(negedge clk);
    chk("t_err_1cyc", {d_ack0, err0}, 0);
    hang = 1'b0;

    force_busy = 1'b1; fdata = 16'h1234; fetch_addr = 16'h0020;
    fetch_req = 1'b1; a = avn;
    repeat (8) @(negedge clk);
    chk("busy_hold", {avn - a, av0}, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_release", {av0, mtype0, maddr0}, {1'b1, 2'b01, 16'h0020});
    wait_ack(0, n);
    chk("b_ack", {f_ack0, err0, f_data0}, {1'b1, 1'b0, 16'h1234});
    fetch_req = 1'b0;
    @(negedge clk);

    fdata = 16'hBEEF; fetch_addr = 16'h0030; fetch_req = 1'b1; a = facks;
    repeat (3) @(negedge clk);
    chk("in_xfer", {mc[0], av0, f_ack0}, {3'd2, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {f_data0, d_rdata0, maddr0, mtype0, av0, f_ack0,
                      d_ack0, err0, mwd0}, 64'h0);
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_ack_rst", {facks - a, f_ack0}, 0);

    fdata = 16'h7E81; fetch_addr = 16'h0042; fetch_req = 1'b1;
    @(negedge clk);
    chk("post_issue", {av0, mtype0, maddr0}, {1'b1, 2'b01, 16'h0042});
    wait_ack(0, n);
    chk("post_ack", {f_ack0, err0, f_data0, n[7:0]},
        {1'b1, 1'b0, 16'h7E81, 8'd4});
    fetch_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
